ide_ata_ctrl: RTL and testbench

//  PIO-mode ATA/IDE register access engine under the RK05 emulation block.

---
 rtl/ide_ata_ctrl.sv | 144 ++++++++++++++
 tb/tb_ide_ata_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ide_ata_ctrl.sv
// PIO-mode ATA/IDE register access engine: turns a held single-register read/write
// request into a timed IDE bus cycle (setup, strobe, recovery) and reports completion.
module ide_ata_ctrl #(
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned PULSE_CYC = 9,
    parameter int unsigned RECOV_CYC = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ata_rd,
    input  logic        ata_wr,
    input  logic [4:0]  ata_addr,
    input  logic [15:0] ata_in,
    output logic [15:0] ata_out,
    output logic        ata_done,
    inout  wire  [15:0] ide_data_bus,
    output logic        ide_dior,
    output logic        ide_diow,
    output logic [1:0]  ide_cs,
    output logic [2:0]  ide_da
);

    localparam int unsigned MaxSP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MaxCyc = (MaxSP > RECOV_CYC) ? MaxSP : RECOV_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] SetupLast = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYC - 1);
    localparam logic [CntW-1:0] RecovLast = CntW'(RECOV_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StRecover
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_d;
    logic              w_accept;
    logic              w_capture;
    logic              w_drive;
    logic              r_is_rd;
    logic [4:0]        r_addr;
    logic [15:0]       r_wdata;
    logic [15:0]       r_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + 1'b1;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (ata_rd || ata_wr) begin
                    w_accept  = 1'b1;
                    w_state_d = StSetup;
                end
            end
            StSetup: begin
                if (r_cnt == SetupLast) begin
                    w_state_d = StStrobe;
                    w_cnt_d   = '0;
                end
            end
            StStrobe: begin
                if (r_cnt == PulseLast) begin
                    // Strobe rises on this edge; read data is sampled on it too.
                    w_capture = r_is_rd;
                    w_state_d = StRecover;
                    w_cnt_d   = '0;
                end
            end
            StRecover: begin
                if (r_cnt == RecovLast) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Request is sampled only on acceptance; later changes are ignored until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_rd <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_is_rd <= ata_rd;
            r_addr  <= ata_addr;
            r_wdata <= ata_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
        end else if (w_capture) begin
            r_out <= ide_data_bus;
        end
    end

    always_comb begin
        ide_cs   = 2'b11;
        ide_da   = 3'b000;
        ide_dior = 1'b1;
        ide_diow = 1'b1;
        ata_done = 1'b0;
        if (r_state != StIdle) begin
            ide_cs = r_addr[4:3];
            ide_da = r_addr[2:0];
        end
        if (r_state == StStrobe) begin
            ide_dior = ~r_is_rd;
            ide_diow = r_is_rd;
        end
        if ((r_state == StRecover) && (r_cnt == RecovLast)) begin
            ata_done = 1'b1;
        end
    end

    assign w_drive      = (r_state != StIdle) && !r_is_rd;
    assign ide_data_bus = w_drive ? r_wdata : 16'hzzzz;
    assign ata_out      = r_out;

endmodule

// File: tb/tb_ide_ata_ctrl.sv
// Directed bench for ide_ata_ctrl: a pulled-up bus plus a device model answering DIOR-,
// with a scoreboard of expected ata_out values popped on each done pulse.
module tb_ide_ata_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ata_rd = 1'b0;
    logic        ata_wr = 1'b0;
    logic [4:0]  ata_addr = '0;
    logic [15:0] ata_in = '0;
    logic [15:0] ata_out;
    logic        ata_done;
    tri1  [15:0] ide_data_bus;
    logic        ide_dior;
    logic        ide_diow;
    logic [1:0]  ide_cs;
    logic [2:0]  ide_da;

    logic [15:0] dev_val = '0;
    logic [15:0] model_out = '0;
    logic [15:0] sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    ide_ata_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ata_rd       (ata_rd),
        .ata_wr       (ata_wr),
        .ata_addr     (ata_addr),
        .ata_in       (ata_in),
        .ata_out      (ata_out),
        .ata_done     (ata_done),
        .ide_data_bus (ide_data_bus),
        .ide_dior     (ide_dior),
        .ide_diow     (ide_diow),
        .ide_cs       (ide_cs),
        .ide_da       (ide_da)
    );

    // Device model: drives read data only while DIOR- is low.
    assign ide_data_bus = (ide_dior == 1'b0) ? dev_val : 16'hzzzz;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " cs"}, 16'(ide_cs), 16'h3);
        chk({tag, " dior"}, 16'(ide_dior), 16'h1);
        chk({tag, " diow"}, 16'(ide_diow), 16'h1);
        chk({tag, " done"}, 16'(ata_done), 16'h0);
    endtask

    // One full transfer, starting with an idle-period check. Period k (1..30) is the k-th
    // clock after acceptance; strobe is k=5..13, done only at k=30.
    task automatic xfer(input logic rd, input logic wr, input logic [4:0] addr,
                        input logic [15:0] wdata, input logic [15:0] dv, input int drop_at,
                        input bit hold, input bit chg, output int done_cyc);
        logic        is_rd;
        logic [15:0] exp_bus;
        logic [15:0] got;
        bit          strobe;
        is_rd    = rd;
        done_cyc = -1;
        @(negedge clk);
        chk_idle("pre-idle");
        ata_rd   = rd;
        ata_wr   = wr;
        ata_addr = addr;
        ata_in   = wdata;
        dev_val  = dv;
        model_out = is_rd ? dv : model_out;
        sb_q.push_back(model_out);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            strobe = (k >= 5) && (k <= 13);
            chk("cs", 16'(ide_cs), 16'(addr[4:3]));
            chk("da", 16'(ide_da), 16'(addr[2:0]));
            chk("dior", 16'(ide_dior), 16'(!(is_rd && strobe)));
            chk("diow", 16'(ide_diow), 16'(!(!is_rd && strobe)));
            chk("done", 16'(ata_done), 16'(k == 30));
            if (is_rd) exp_bus = strobe ? dv : 16'hffff;
            else       exp_bus = wdata;
            chk("bus", ide_data_bus, exp_bus);
            if (ata_done) begin
                done_cyc = cyc;
                if (sb_q.size() == 0) begin
                    chk("sb underflow", 16'h1, 16'h0);
                end else begin
                    got = sb_q.pop_front();
                    chk("ata_out@done", ata_out, got);
                end
            end
            if (k == drop_at) begin
                ata_rd = 1'b0;
                ata_wr = 1'b0;
            end
            if (chg && k == 3) begin
                ata_addr = ~addr;
                ata_in   = ~wdata;
            end
        end
        if (!hold) begin
            ata_rd = 1'b0;
            ata_wr = 1'b0;
        end
    endtask

    initial begin
        int d0, d1, d2, n_done;

        // Reset values while reset is held from time zero.
        #1;
        chk("rst cs", 16'(ide_cs), 16'h3);
        chk("rst dior", 16'(ide_dior), 16'h1);
        chk("rst diow", 16'(ide_diow), 16'h1);
        chk("rst da", 16'(ide_da), 16'h0);
        chk("rst bus", ide_data_bus, 16'hffff);
        chk("rst out", ata_out, 16'h0000);
        chk("rst done", 16'(ata_done), 16'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Command-block read, then a write that must not touch ata_out.
        xfer(1'b1, 1'b0, 5'b10111, 16'h0000, 16'h0050, 0, 1'b0, 1'b0, d0);
        repeat (3) @(negedge clk);
        chk("out held idle", ata_out, 16'h0050);
        xfer(1'b0, 1'b1, 5'b10110, 16'h0040, 16'h0000, 0, 1'b0, 1'b0, d0);
        chk("out after wr", ata_out, 16'h0050);

        // Asynchronous reset in the middle of a write strobe.
        @(negedge clk);
        ata_wr   = 1'b1;
        ata_addr = 5'b10110;
        ata_in   = 16'h0040;
        repeat (7) @(negedge clk);
        chk("pre-rst diow", 16'(ide_diow), 16'h0);
        #2 reset = 1'b1;
        #1;
        ata_wr = 1'b0;
        chk("arst cs", 16'(ide_cs), 16'h3);
        chk("arst dior", 16'(ide_dior), 16'h1);
        chk("arst diow", 16'(ide_diow), 16'h1);
        chk("arst bus", ide_data_bus, 16'hffff);
        chk("arst out", ata_out, 16'h0000);
        chk("arst done", 16'(ata_done), 16'h0);
        model_out = 16'h0000;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (ata_done) n_done++;
        end
        chk("no done after rst", 16'(n_done), 16'h0);
        chk_idle("post-rst");

        // Control block: read, then a write that leaves ata_out alone.
        xfer(1'b1, 1'b0, 5'b01110, 16'h0000, 16'h00a5, 0, 1'b0, 1'b0, d0);
        xfer(1'b0, 1'b1, 5'b01110, 16'h1234, 16'h0000, 0, 1'b0, 1'b0, d0);
        chk("ctl out after wr", ata_out, 16'h00a5);

        // Back-to-back reads with the request held; last one has rd and wr both high.
        xfer(1'b1, 1'b0, 5'b10111, 16'h0000, 16'h1357, 0, 1'b1, 1'b0, d0);
        xfer(1'b1, 1'b0, 5'b10111, 16'h0000, 16'h2468, 0, 1'b1, 1'b0, d1);
        xfer(1'b1, 1'b1, 5'b10111, 16'hffff, 16'h0bad, 0, 1'b0, 1'b0, d2);
        chk("b2b gap1", 16'(d1 - d0), 16'd31);
        chk("b2b gap2", 16'(d2 - d1), 16'd31);
        chk("rd prio out", ata_out, 16'h0bad);

        // Write dropped mid-setup, address/data changed mid-cycle: completes once, then idle.
        xfer(1'b0, 1'b1, 5'b10110, 16'h00c3, 16'h0000, 2, 1'b0, 1'b1, d0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ata_done) n_done++;
            chk("stay idle cs", 16'(ide_cs), 16'h3);
        end
        chk("no extra done", 16'(n_done), 16'h0);
        chk("out after drop", ata_out, 16'h0bad);
        chk("sb empty", 16'(sb_q.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
